// File: rtl/proc_controller_p_if.sv
// Instruction-fetch handshake plus the Datapath control bus between the controller and Datapath.
interface proc_controller_p_if #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned RF_AW = 4
);
  localparam int unsigned D_AW    = 2 * RF_AW;
  localparam int unsigned INSTR_W = 4 + 3 * RF_AW;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_valid;
  logic [INSTR_W-1:0] imem_data;
  logic               alu_zero;
  logic [D_AW-1:0]    D_addr;
  logic               D_wr;
  logic               RF_s;
  logic [RF_AW-1:0]   RF_W_addr;
  logic               RF_W_en;
  logic [RF_AW-1:0]   RF_Ra_addr;
  logic [RF_AW-1:0]   RF_Rb_addr;
  logic [2:0]         ALU_s0;

  modport master (
    output imem_req, imem_addr,
    input  imem_valid, imem_data, alu_zero,
    output D_addr, D_wr, RF_s, RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_valid, imem_data, alu_zero,
    input  D_addr, D_wr, RF_s, RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0
  );
endinterface

// File: rtl/proc_controller_p.sv
// Multi-cycle processor controller: imem fetch with timeout/fault, decode, and Datapath control.
module proc_controller_p #(
  parameter  int unsigned PC_W         = 8,
  parameter  int unsigned RF_AW        = 4,
  parameter  int unsigned IMEM_TIMEOUT = 15,
  localparam int unsigned D_AW         = 2 * RF_AW,
  localparam int unsigned INSTR_W      = 4 + 3 * RF_AW
) (
  input  logic               Clock,
  input  logic               ResetN,
  proc_controller_p_if.master bus,
  output logic [PC_W-1:0]    PC_Out,
  output logic [INSTR_W-1:0] IR_Out,
  output logic [3:0]         State,
  output logic [3:0]         NextState,
  output logic               halted,
  output logic               fault
);

  localparam int unsigned CNT_W = (IMEM_TIMEOUT < 2) ? 1 : $clog2(IMEM_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_INIT       = 4'd0,
    S_FETCH      = 4'd1,
    S_FETCH_WAIT = 4'd2,
    S_DECODE     = 4'd3,
    S_NOOP       = 4'd4,
    S_LOAD_A     = 4'd5,
    S_LOAD_B     = 4'd6,
    S_STORE      = 4'd7,
    S_ADD        = 4'd8,
    S_SUB        = 4'd9,
    S_JZ         = 4'd10,
    S_HALT       = 4'd11
  } state_t;

  state_t             r_state;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic               r_fault;

  logic               r_imem_req;
  logic [D_AW-1:0]    r_d_addr;
  logic               r_d_wr;
  logic               r_rf_s;
  logic [RF_AW-1:0]   r_rf_w_addr;
  logic               r_rf_w_en;
  logic [RF_AW-1:0]   r_rf_ra;
  logic [RF_AW-1:0]   r_rf_rb;
  logic [2:0]         r_alu_s0;
  logic               r_halted;

  state_t             w_next_state;
  logic [PC_W-1:0]    w_next_pc;
  logic [INSTR_W-1:0] w_next_ir;
  logic [CNT_W-1:0]   w_next_cnt;
  logic               w_next_fault;
  logic [31:0]        w_wait_inc;
  logic [3:0]         w_opcode;

  logic               w_imem_req;
  logic [D_AW-1:0]    w_d_addr;
  logic               w_d_wr;
  logic               w_rf_s;
  logic [RF_AW-1:0]   w_rf_w_addr;
  logic               w_rf_w_en;
  logic [RF_AW-1:0]   w_rf_ra;
  logic [RF_AW-1:0]   w_rf_rb;
  logic [2:0]         w_alu_s0;
  logic               w_halted;

  logic [RF_AW-1:0]   w_n_a;
  logic [RF_AW-1:0]   w_n_b;
  logic [RF_AW-1:0]   w_n_c;
  logic [D_AW-1:0]    w_n_k;
  logic [D_AW-1:0]    w_n_ld_addr;

  assign w_opcode    = r_ir[INSTR_W-1 -: 4];
  assign w_wait_inc  = 32'(r_wait_cnt) + 32'd1;

  assign w_n_a       = w_next_ir[3*RF_AW-1 -: RF_AW];
  assign w_n_b       = w_next_ir[2*RF_AW-1 -: RF_AW];
  assign w_n_c       = w_next_ir[RF_AW-1:0];
  assign w_n_k       = w_next_ir[D_AW-1:0];
  assign w_n_ld_addr = w_next_ir[D_AW+RF_AW-1:RF_AW];

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_ir    = r_ir;
    w_next_cnt   = r_wait_cnt;
    w_next_fault = r_fault;
    case (r_state)
      S_INIT:  w_next_state = S_FETCH;
      S_FETCH: begin
        w_next_state = S_FETCH_WAIT;
        w_next_cnt   = '0;
      end
      S_FETCH_WAIT: begin
        // An instruction arriving on the expiry cycle still wins over the timeout.
        if (bus.imem_valid) begin
          w_next_ir    = bus.imem_data;
          w_next_pc    = r_pc + 1'b1;
          w_next_cnt   = '0;
          w_next_state = S_DECODE;
        end else if (IMEM_TIMEOUT != 0) begin
          if (w_wait_inc == IMEM_TIMEOUT) begin
            w_next_fault = 1'b1;
            w_next_cnt   = '0;
            w_next_state = S_HALT;
          end else begin
            w_next_cnt = CNT_W'(w_wait_inc);
          end
        end
      end
      S_DECODE: begin
        case (w_opcode)
          4'd1:    w_next_state = S_STORE;
          4'd2:    w_next_state = S_LOAD_A;
          4'd3:    w_next_state = S_ADD;
          4'd4:    w_next_state = S_SUB;
          4'd5:    w_next_state = S_HALT;
          4'd6:    w_next_state = S_JZ;
          default: w_next_state = S_NOOP;
        endcase
      end
      S_LOAD_A: w_next_state = S_LOAD_B;
      S_JZ: begin
        if (bus.alu_zero) w_next_pc = PC_W'(r_ir[D_AW-1:0]);
        w_next_state = S_FETCH;
      end
      S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: w_next_state = S_FETCH;
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_INIT;
    endcase
  end

  // Control outputs are decoded from the upcoming state/IR and registered, so they
  // equal a decode of the current State/IR while coming straight from flops.
  always_comb begin
    w_imem_req  = 1'b0;
    w_d_addr    = '0;
    w_d_wr      = 1'b0;
    w_rf_s      = 1'b0;
    w_rf_w_addr = '0;
    w_rf_w_en   = 1'b0;
    w_rf_ra     = '0;
    w_rf_rb     = '0;
    w_alu_s0    = 3'd0;
    w_halted    = 1'b0;
    case (w_next_state)
      S_FETCH, S_FETCH_WAIT: w_imem_req = 1'b1;
      S_STORE: begin
        w_d_addr = w_n_k;
        w_rf_ra  = w_n_a;
        w_d_wr   = 1'b1;
      end
      S_LOAD_A: w_d_addr = w_n_ld_addr;
      S_LOAD_B: begin
        w_d_addr    = w_n_ld_addr;
        w_rf_s      = 1'b1;
        w_rf_w_addr = w_n_c;
        w_rf_w_en   = 1'b1;
      end
      S_ADD, S_SUB: begin
        w_rf_ra     = w_n_a;
        w_rf_rb     = w_n_b;
        w_alu_s0    = (w_next_state == S_ADD) ? 3'd1 : 3'd2;
        w_rf_w_addr = w_n_c;
        w_rf_w_en   = 1'b1;
      end
      S_JZ:    w_rf_ra  = w_n_a;
      S_HALT:  w_halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_state     <= S_INIT;
      r_pc        <= '0;
      r_ir        <= '0;
      r_wait_cnt  <= '0;
      r_fault     <= 1'b0;
      r_imem_req  <= 1'b0;
      r_d_addr    <= '0;
      r_d_wr      <= 1'b0;
      r_rf_s      <= 1'b0;
      r_rf_w_addr <= '0;
      r_rf_w_en   <= 1'b0;
      r_rf_ra     <= '0;
      r_rf_rb     <= '0;
      r_alu_s0    <= 3'd0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_pc        <= w_next_pc;
      r_ir        <= w_next_ir;
      r_wait_cnt  <= w_next_cnt;
      r_fault     <= w_next_fault;
      r_imem_req  <= w_imem_req;
      r_d_addr    <= w_d_addr;
      r_d_wr      <= w_d_wr;
      r_rf_s      <= w_rf_s;
      r_rf_w_addr <= w_rf_w_addr;
      r_rf_w_en   <= w_rf_w_en;
      r_rf_ra     <= w_rf_ra;
      r_rf_rb     <= w_rf_rb;
      r_alu_s0    <= w_alu_s0;
      r_halted    <= w_halted;
    end
  end

  assign bus.imem_req   = r_imem_req;
  assign bus.imem_addr  = r_pc;
  assign bus.D_addr     = r_d_addr;
  assign bus.D_wr       = r_d_wr;
  assign bus.RF_s       = r_rf_s;
  assign bus.RF_W_addr  = r_rf_w_addr;
  assign bus.RF_W_en    = r_rf_w_en;
  assign bus.RF_Ra_addr = r_rf_ra;
  assign bus.RF_Rb_addr = r_rf_rb;
  assign bus.ALU_s0     = r_alu_s0;

  assign PC_Out    = r_pc;
  assign IR_Out    = r_ir;
  assign State     = r_state;
  assign NextState = w_next_state;
  assign halted    = r_halted;
  assign fault     = r_fault;

endmodule

// File: tb/tb_proc_controller_p.sv
// Directed bench for proc_controller_p at default parameters (PC_W=8, RF_AW=4, IMEM_TIMEOUT=15).
module tb_proc_controller_p;

  logic        Clock = 1'b0;
  logic        ResetN = 1'b0;
  logic [7:0]  PC_Out;
  logic [15:0] IR_Out;
  logic [3:0]  State;
  logic [3:0]  NextState;
  logic        halted;
  logic        fault;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  proc_controller_p_if #(.PC_W(8), .RF_AW(4)) bus ();

  proc_controller_p #(.PC_W(8), .RF_AW(4), .IMEM_TIMEOUT(15)) dut (
    .Clock     (Clock),
    .ResetN    (ResetN),
    .bus       (bus),
    .PC_Out    (PC_Out),
    .IR_Out    (IR_Out),
    .State     (State),
    .NextState (NextState),
    .halted    (halted),
    .fault     (fault)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Starts in FETCH; leaves the controller in DECODE with the word latched.
  task automatic fetch(input logic [15:0] instr);
    tick();
    bus.imem_valid = 1'b1;
    bus.imem_data  = instr;
    tick();
    bus.imem_valid = 1'b0;
  endtask

  initial begin
    bus.imem_valid = 1'b0;
    bus.imem_data  = '0;
    bus.alu_zero   = 1'b0;

    repeat (2) tick();
    chk("rst_state", 32'(State), 32'd0);
    chk("rst_pc", 32'(PC_Out), 32'd0);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_wen", 32'(bus.RF_W_en), 32'd0);

    ResetN = 1'b1;
    chk("init_after_release", 32'(State), 32'd0);
    tick();
    chk("fetch_state", 32'(State), 32'd1);
    chk("fetch_req", 32'(bus.imem_req), 32'd1);
    chk("fetch_next", 32'(NextState), 32'd2);
    tick();
    tick();
    tick();
    chk("fw_state", 32'(State), 32'd2);
    chk("fw_req", 32'(bus.imem_req), 32'd1);

    // Reset while waiting on imem
    ResetN = 1'b0;
    #1;
    chk("midrst_req", 32'(bus.imem_req), 32'd0);
    chk("midrst_state", 32'(State), 32'd0);
    chk("midrst_pc", 32'(PC_Out), 32'd0);
    #2 ResetN = 1'b1;
    chk("midrst_init", 32'(State), 32'd0);
    tick();
    chk("midrst_fetch", 32'(State), 32'd1);

    // ADD after three wait cycles
    tick();
    tick();
    tick();
    bus.imem_valid = 1'b1;
    bus.imem_data  = 16'h3123;
    tick();
    bus.imem_valid = 1'b0;
    chk("add_ir", 32'(IR_Out), 32'h3123);
    chk("add_pc", 32'(PC_Out), 32'd1);
    chk("add_decode", 32'(State), 32'd3);
    chk("add_next", 32'(NextState), 32'd8);
    tick();
    chk("add_state", 32'(State), 32'd8);
    chk("add_ra", 32'(bus.RF_Ra_addr), 32'd1);
    chk("add_rb", 32'(bus.RF_Rb_addr), 32'd2);
    chk("add_waddr", 32'(bus.RF_W_addr), 32'd3);
    chk("add_wen", 32'(bus.RF_W_en), 32'd1);
    chk("add_alu", 32'(bus.ALU_s0), 32'd1);
    chk("add_rfs", 32'(bus.RF_s), 32'd0);
    tick();
    chk("add_back", 32'(State), 32'd1);
    chk("add_addr", 32'(bus.imem_addr), 32'd1);
    chk("add_wen_off", 32'(bus.RF_W_en), 32'd0);

    // LOAD
    fetch(16'h2A57);
    chk("ld_pc", 32'(PC_Out), 32'd2);
    tick();
    chk("lda_state", 32'(State), 32'd5);
    chk("lda_daddr", 32'(bus.D_addr), 32'hA5);
    chk("lda_wen", 32'(bus.RF_W_en), 32'd0);
    tick();
    chk("ldb_state", 32'(State), 32'd6);
    chk("ldb_daddr", 32'(bus.D_addr), 32'hA5);
    chk("ldb_rfs", 32'(bus.RF_s), 32'd1);
    chk("ldb_waddr", 32'(bus.RF_W_addr), 32'd7);
    chk("ldb_wen", 32'(bus.RF_W_en), 32'd1);
    tick();
    chk("ld_back", 32'(State), 32'd1);

    // Valid during FETCH is ignored; STORE
    bus.imem_valid = 1'b1;
    bus.imem_data  = 16'h134C;
    tick();
    chk("fetch_valid_ignored", 32'(State), 32'd2);
    chk("fetch_valid_ir", 32'(IR_Out), 32'h2A57);
    tick();
    bus.imem_valid = 1'b0;
    chk("st_ir", 32'(IR_Out), 32'h134C);
    chk("st_pc", 32'(PC_Out), 32'd3);
    tick();
    chk("st_state", 32'(State), 32'd7);
    chk("st_daddr", 32'(bus.D_addr), 32'h4C);
    chk("st_ra", 32'(bus.RF_Ra_addr), 32'd3);
    chk("st_dwr", 32'(bus.D_wr), 32'd1);
    chk("st_wen", 32'(bus.RF_W_en), 32'd0);
    tick();
    chk("st_dwr_off", 32'(bus.D_wr), 32'd0);

    // JZ taken
    fetch(16'h6240);
    chk("jz1_pc", 32'(PC_Out), 32'd4);
    tick();
    chk("jz1_state", 32'(State), 32'd10);
    chk("jz1_ra", 32'(bus.RF_Ra_addr), 32'd2);
    chk("jz1_alu", 32'(bus.ALU_s0), 32'd0);
    bus.alu_zero = 1'b1;
    tick();
    bus.alu_zero = 1'b0;
    chk("jz1_taken_pc", 32'(PC_Out), 32'h40);
    chk("jz1_addr", 32'(bus.imem_addr), 32'h40);

    // JZ not taken
    fetch(16'h6240);
    chk("jz2_pc", 32'(PC_Out), 32'h41);
    tick();
    tick();
    chk("jz2_not_taken_pc", 32'(PC_Out), 32'h41);

    // Jump to FF then check wrap
    fetch(16'h60FF);
    tick();
    bus.alu_zero = 1'b1;
    tick();
    bus.alu_zero = 1'b0;
    chk("jz3_pc", 32'(PC_Out), 32'hFF);
    fetch(16'h0000);
    chk("wrap_pc", 32'(PC_Out), 32'h00);
    tick();
    chk("noop_state", 32'(State), 32'd4);
    tick();
    chk("noop_back", 32'(State), 32'd1);

    // SUB
    fetch(16'h4125);
    tick();
    chk("sub_state", 32'(State), 32'd9);
    chk("sub_alu", 32'(bus.ALU_s0), 32'd2);
    chk("sub_waddr", 32'(bus.RF_W_addr), 32'd5);
    chk("sub_wen", 32'(bus.RF_W_en), 32'd1);
    tick();

    // Unused opcode behaves as NOOP
    fetch(16'hF000);
    tick();
    chk("opF_state", 32'(State), 32'd4);
    chk("opF_wen", 32'(bus.RF_W_en), 32'd0);
    chk("opF_dwr", 32'(bus.D_wr), 32'd0);
    tick();
    chk("opF_back", 32'(State), 32'd1);

    // Valid on the 15th wait cycle beats the timeout
    tick();
    repeat (14) tick();
    chk("w15_still_wait", 32'(State), 32'd2);
    bus.imem_valid = 1'b1;
    bus.imem_data  = 16'h0000;
    tick();
    bus.imem_valid = 1'b0;
    chk("w15_decode", 32'(State), 32'd3);
    chk("w15_nofault", 32'(fault), 32'd0);
    tick();
    tick();
    chk("w15_back", 32'(State), 32'd1);

    // Timeout after 15 wait cycles
    tick();
    repeat (14) tick();
    chk("to_wait14", 32'(State), 32'd2);
    tick();
    chk("to_state", 32'(State), 32'd11);
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_halted", 32'(halted), 32'd1);
    chk("to_req", 32'(bus.imem_req), 32'd0);
    bus.imem_valid = 1'b1;
    bus.imem_data  = 16'h3123;
    repeat (3) tick();
    bus.imem_valid = 1'b0;
    chk("to_sticky_state", 32'(State), 32'd11);
    chk("to_sticky_ir", 32'(IR_Out), 32'h0000);
    chk("to_sticky_fault", 32'(fault), 32'd1);

    // Reset clears fault; then HALT instruction
    ResetN = 1'b0;
    #1;
    chk("rst2_fault", 32'(fault), 32'd0);
    chk("rst2_halted", 32'(halted), 32'd0);
    #2 ResetN = 1'b1;
    tick();
    fetch(16'h5000);
    tick();
    chk("halt_state", 32'(State), 32'd11);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_nofault", 32'(fault), 32'd0);
    bus.imem_valid = 1'b1;
    bus.imem_data  = 16'h1123;
    repeat (4) tick();
    bus.imem_valid = 1'b0;
    chk("halt_abs_state", 32'(State), 32'd11);
    chk("halt_abs_wen", 32'(bus.RF_W_en), 32'd0);
    chk("halt_abs_dwr", 32'(bus.D_wr), 32'd0);
    chk("halt_abs_req", 32'(bus.imem_req), 32'd0);
    chk("halt_abs_pc", 32'(PC_Out), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
